// File: rtl/reg_en_sequencer.sv
// rtl/reg_en_sequencer.sv - registered one-hot write-enable sequencer, single/burst with wrap; define RANGE_ERR_EN to add err_o
module reg_en_sequencer #(
    parameter int NREG = 7,
    parameter int AW   = 3
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic            start_i,
    input  logic            mode_i,
    input  logic [AW-1:0]   base_i,
    input  logic [AW:0]     count_i,
    output logic [NREG-1:0] y_o,
    output logic [AW-1:0]   idx_o,
    output logic            busy_o,
    output logic            done_o
`ifdef RANGE_ERR_EN
    ,
    output logic            err_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    localparam logic [AW:0]     NREG_W   = (AW+1)'(NREG);
    localparam logic [AW-1:0]   LAST_IDX = AW'(NREG - 1);
    localparam logic [NREG-1:0] ONE      = NREG'(1);

    state_e          state_q;
    logic [NREG-1:0] y_q;
    logic [AW-1:0]   idx_q;
    logic [AW:0]     rem_q;
    logic            busy_q;
    logic            done_q;
`ifdef RANGE_ERR_EN
    logic            err_q;
`endif

    logic            base_ok_d;
    logic [AW:0]     cnt_eff_d;

    // Index after i, wrapping from the last register back to 0
    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    // Request qualification: single mode always issues exactly one enable
    always_comb begin
        base_ok_d = ({1'b0, base_i} < NREG_W);
        cnt_eff_d = mode_i ? count_i : (AW+1)'(1);
    end

    // Sequencer FSM; every output is a register so y_o is glitch-free
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            y_q     <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef RANGE_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef RANGE_ERR_EN
            err_q  <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    y_q <= '0;
                    if (start_i && en_i) begin
                        if (!base_ok_d) begin
`ifdef RANGE_ERR_EN
                            err_q <= 1'b1;
`endif
                        end else if (cnt_eff_d != '0) begin
                            y_q     <= ONE << base_i;
                            idx_q   <= wrap_inc(base_i);
                            rem_q   <= cnt_eff_d - 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (!en_i) begin
                        // stall: idx/rem hold so the total enable count is preserved
                        y_q <= '0;
                    end else if (rem_q != '0) begin
                        y_q   <= ONE << idx_q;
                        idx_q <= wrap_inc(idx_q);
                        rem_q <= rem_q - 1'b1;
                    end else begin
                        y_q     <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    y_q     <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    y_q     <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign y_o    = y_q;
    assign idx_o  = idx_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
`ifdef RANGE_ERR_EN
    assign err_o  = err_q;
`endif

endmodule

// File: tb/tb_reg_en_sequencer.sv
// tb/tb_reg_en_sequencer.sv - transaction-level scoreboard bench for reg_en_sequencer
module tb_reg_en_sequencer;

    localparam int NREG = 7;
    localparam int AW   = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic            start;
    logic            mode;
    logic [AW-1:0]   base;
    logic [AW:0]     count;
    logic [NREG-1:0] y;
    logic [AW-1:0]   idx;
    logic            busy;
    logic            done;
`ifdef RANGE_ERR_EN
    logic            err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reg_en_sequencer #(.NREG(NREG), .AW(AW)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .en_i    (en),
        .start_i (start),
        .mode_i  (mode),
        .base_i  (base),
        .count_i (count),
        .y_o     (y),
        .idx_o   (idx),
        .busy_o  (busy),
        .done_o  (done)
`ifdef RANGE_ERR_EN
        ,
        .err_o   (err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] oh(input int i);
        return 32'd1 << i;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_err(input logic e);
`ifdef RANGE_ERR_EN
        check("err", {31'd0, err}, {31'd0, e});
`endif
    endtask

    // One request; expected enables are (b + k) mod NREG for k < Count_eff
    task automatic run_txn(input logic m, input int b, input int c,
                           input logic use_mask, input logic [31:0] mask, input logic noisy);
        int   ceff;
        int   issued;
        int   cyc;
        logic e;
        en    = 1'b1;
        start = 1'b1;
        mode  = m;
        base  = b[AW-1:0];
        count = c[AW:0];
        tick;
        start = 1'b0;
        ceff  = m ? c : 1;
        if (b >= NREG) begin
            check("rej_y", y, 0);
            check("rej_busy", busy, 0);
            check("rej_done", done, 0);
            check_err(1'b1);
            tick;
            check_err(1'b0);
            check("rej_y2", y, 0);
            check("rej_busy2", busy, 0);
            return;
        end
        check_err(1'b0);
        if (ceff == 0) begin
            check("c0_y", y, 0);
            check("c0_busy", busy, 0);
            check("c0_done", done, 1);
            start = noisy;
            base  = 3'd1;
            tick;
            start = 1'b0;
            check("c0_done2", done, 0);
            check("c0_y2", y, 0);
            check("c0_busy2", busy, 0);
            return;
        end
        check("y_first", y, oh(b));
        check("busy_first", busy, 1);
        check("done_first", done, 0);
        check("idx_first", idx, (b + 1) % NREG);
        issued = 1;
        cyc    = 0;
        forever begin
            if (cyc > 200) begin
                check("burst_timeout", 32'(cyc), 32'd0);
                return;
            end
            e  = use_mask ? mask[cyc % 32] : ($urandom_range(0, 3) != 0);
            en = e;
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                base  = AW'($urandom_range(0, NREG - 1));
                mode  = 1'($urandom_range(0, 1));
                count = (AW+1)'($urandom_range(0, 15));
            end
            tick;
            cyc++;
            if (!e) begin
                check("stall_y", y, 0);
                check("stall_busy", busy, 1);
                check("stall_done", done, 0);
                check("stall_idx", idx, (b + issued) % NREG);
            end else if (issued < ceff) begin
                check("run_y", y, oh((b + issued) % NREG));
                check("run_busy", busy, 1);
                check("run_done", done, 0);
                issued++;
                check("run_idx", idx, (b + issued) % NREG);
            end else begin
                check("end_y", y, 0);
                check("end_busy", busy, 0);
                check("end_done", done, 1);
                break;
            end
        end
        en    = 1'b1;
        start = noisy;
        mode  = 1'b0;
        base  = '0;
        tick;
        start = 1'b0;
        check("idle_y", y, 0);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        base  = '0;
        count = '0;
        repeat (2) tick;
        check("rst_y", y, 0);
        check("rst_idx", idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check_err(1'b0);
        rst_n = 1'b1;
        tick;

        // directed cases
        run_txn(1'b0, 4, 6, 1'b1, 32'hFFFF_FFFF, 1'b0);
        run_txn(1'b1, 5, 4, 1'b1, 32'hFFFF_FFFF, 1'b0);
        run_txn(1'b1, 5, 4, 1'b1, 32'hFFFF_FFF9, 1'b0);
        run_txn(1'b1, 3, 0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        run_txn(1'b1, 1, 6, 1'b1, 32'hFFFF_FFFF, 1'b1);
        run_txn(1'b1, 6, 15, 1'b1, 32'hFFFF_FFFF, 1'b0);
        run_txn(1'b0, 7, 1, 1'b1, 32'hFFFF_FFFF, 1'b0);

        // start with en low is ignored
        en    = 1'b0;
        start = 1'b1;
        base  = 3'd3;
        mode  = 1'b0;
        tick;
        start = 1'b0;
        en    = 1'b1;
        check("en0_y", y, 0);
        check("en0_busy", busy, 0);
        check("en0_done", done, 0);

        // asynchronous reset in the middle of a burst
        start = 1'b1;
        mode  = 1'b1;
        base  = 3'd2;
        count = 4'd5;
        tick;
        start = 1'b0;
        check("rb_y1", y, oh(2));
        tick;
        check("rb_y2", y, oh(3));
        #1 rst_n = 1'b0;
        #1;
        check("rb_y", y, 0);
        check("rb_busy", busy, 0);
        check("rb_done", done, 0);
        check("rb_idx", idx, 0);
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            check("rb_nodone", done, 0);
            check("rb_noy", y, 0);
        end

        // randomized transactions
        for (int i = 0; i < 60; i++) begin
            run_txn(1'($urandom_range(0, 1)), int'($urandom_range(0, NREG)),
                    int'($urandom_range(0, 15)), 1'b0, 32'd0, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_en_sequencer.md
Name: reg_en_sequencer

Overview:
- Parametrised, registered one-hot register-write-enable generator for the processor datapath.
- Successor to the fixed 3-bit register-enable decoder.
- Single mode: one enable pulse on the selected register.
- Burst mode: walks consecutive registers, one per cycle, with wrap-around. Used for multi-register load/store and reset-clear sequences.
- Busy/Done handshake toward the control FSM.

Parameters:
- NREG, 7, number of registers / width of the one-hot output (2..2^AW).
- AW, 3, index width; 2^AW >= NREG is required.

Ports:
- Clock  input  1  rising-edge clock.
- Resetn  input  1  asynchronous, active-low reset.
- En  input  1  global enable. 0 forces Y to zero next edge and stalls the sequence.
- Start  input  1  request pulse, sampled in IDLE only.
- Mode  input  1  0 = single (Count ignored, treated as 1), 1 = burst.
- Base  input  AW  first register index.
- Count  input  AW+1  number of enables in burst mode.
- Y  output  NREG  registered one-hot write enable.
- Idx  output  AW  next index to be enabled (debug/observe).
- Busy  output  1  high in RUN.
- Done  output  1  one-cycle completion pulse.
- Err  output  1  present only with RANGE_ERR_EN; one-cycle error pulse.

Behaviour:
- Reset (async, Resetn=0): state=IDLE; Y=0, Idx=0, Busy=0, Done=0, Err=0. Reset mid-burst aborts immediately, with no Done.
- IDLE, accept condition: edge with Start=1, En=1 and Base<NREG.
  - Count_eff = 1 in single mode, Count in burst mode.
  - If Count_eff>0: Y<=onehot(Base), Idx<=(Base+1) mod NREG, rem<=Count_eff-1, state<=RUN, Busy<=1.
  - If Count_eff==0: Y stays 0, Done<=1, state<=DONE.
- IDLE, Start ignored when En=0.
- IDLE, Base>=NREG: Start rejected; Y stays 0 and state stays IDLE (Err pulses if enabled).
- RUN, En=1 and rem>0: Y<=onehot(Idx), Idx<=(Idx+1) mod NREG, rem<=rem-1.
- RUN, En=1 and rem==0: Y<=0, Busy<=0, Done<=1, state<=DONE.
- RUN, En=0: Y<=0; Idx and rem hold (stall). On resume, the next edge enables Idx. Total enables always equal Count_eff.
- DONE: Done<=0, state<=IDLE. Start is not accepted in DONE. It can be accepted on the edge after DONE.
- Start while Busy or in DONE: ignored, with no queuing.
- Latency: the first Y bit is high after the accepting edge. A burst of N occupies N cycles of Y, then one Done cycle, then IDLE.
- Wrap: the index after NREG-1 is 0. Count>NREG is legal and repeats registers.
- Y is never multi-hot. Y is zero whenever the state is not RUN-with-enable.

Optional Feature:
- Macro RANGE_ERR_EN.
- Defined: Err port exists. Err<=1 for exactly one cycle on an IDLE edge where Start=1, En=1 and Base>=NREG (the Start is rejected). Otherwise Err=0.
- Undefined: no Err port; out-of-range Start is silently rejected.
- Without the macro, behaviour on every other output is identical.

Test Plan:
- Reset during a burst: NREG=7, Mode=1, Base=2, Count=5, pulse Resetn low after the second enable. Required: Y=0, Busy=0, Done=0 immediately (async); no Done afterwards.
- Single mode: Mode=0, Base=4, Count=6, Start 1 cycle. Required: Y=7'b0010000 for exactly 1 cycle, then Y=0 with Done=1, then IDLE.
- Burst with wrap: NREG=7, Mode=1, Base=5, Count=4. Required: Y sequence 0100000, 1000000, 0000001, 0000010, then Done.
- Stall: same burst with En=0 for 2 cycles after the second enable. Required: Y=0 and Idx=0 held during the stall; the sequence resumes with 0000001; 4 enables total.
- Count=0 burst: Required: Y never asserted, Done pulses on the edge after Start. Start during Busy: ignored, and the current burst completes unchanged.
- Base=7 with NREG=7: Required: no Y, state stays IDLE. With RANGE_ERR_EN defined, Err=1 for one cycle; without it, no Err port.
